// File: rtl/parking_pay_station_if.sv
// parking_pay_station_if: ticket, coin and payment-result signals of the exit pay station
interface parking_pay_station_if #(parameter int TW = 8, parameter int FEE_W = 12);
  logic             tick;
  logic             ticket_valid;
  logic [TW-1:0]    ticket_time;
  logic             coin_valid;
  logic [3:0]       coin_value;
  logic             cancel;
  logic             pay;
  logic             busy;
  logic [FEE_W-1:0] fee_due;
  logic             change_valid;
  logic [FEE_W-1:0] change;
  logic             refund_valid;
  logic [FEE_W-1:0] refund;
  modport master (output tick, ticket_valid, ticket_time, coin_valid, coin_value, cancel,
                  input pay, busy, fee_due, change_valid, change, refund_valid, refund);
  modport slave (input tick, ticket_valid, ticket_time, coin_valid, coin_value, cancel,
                 output pay, busy, fee_due, change_valid, change, refund_valid, refund);
endinterface

// File: rtl/parking_pay_station.sv
// parking_pay_station: exit pay terminal computing time-based fee, collecting coins, paying out change/refund
// Optional free grace period enabled by defining PARKING_GRACE_PERIOD_EN.
module parking_pay_station #(
  parameter int TW      = 8,
  parameter int RATE    = 2,
  parameter int FEE_W   = 12,
  parameter int TIMEOUT = 255,
  parameter int GRACE   = 3
) (
  input logic clk,
  input logic rst,
  parking_pay_station_if.slave io
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CALC    = 3'd1;
  localparam logic [2:0] COLLECT = 3'd2;
  localparam logic [2:0] PAID    = 3'd3;
  localparam logic [2:0] REFUND  = 3'd4;
  localparam int CW = $clog2(TIMEOUT + 1);
`ifdef PARKING_GRACE_PERIOD_EN
  localparam bit GRACE_EN = 1'b1;
`else
  localparam bit GRACE_EN = 1'b0;
`endif
  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    now_q, now_d, tt_q, tt_d;
  logic [FEE_W-1:0] credit_q, credit_d, fee_q, fee_d, chg_q, chg_d, ref_q, ref_d;
  logic [CW-1:0]    to_q, to_d;
  logic             pay_q, pay_d, busy_q, busy_d, chg_v_q, chg_v_d, ref_v_q, ref_v_d;
  logic [TW-1:0]    elapsed;
  logic [FEE_W-1:0] fee_calc;
  logic [FEE_W:0]   sum;
  logic             grace_hit, done;
  always_comb begin
    elapsed   = now_q - tt_q;
    fee_calc  = FEE_W'((elapsed == '0 ? 32'd1 : 32'(elapsed)) * RATE);
    grace_hit = GRACE_EN && (int'(elapsed) <= GRACE);
    sum       = {1'b0, credit_q} + (FEE_W+1)'(io.coin_value);
    done      = io.coin_valid && (sum >= {1'b0, fee_q});
    state_d   = state_q;
    now_d     = now_q + TW'(io.tick);
    tt_d      = tt_q;
    credit_d  = credit_q;
    to_d      = to_q;
    fee_d     = fee_q;
    chg_d     = chg_q;
    ref_d     = ref_q;
    pay_d     = 1'b0;
    chg_v_d   = 1'b0;
    ref_v_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tt_d    = io.ticket_valid ? io.ticket_time : tt_q;
        state_d = io.ticket_valid ? CALC : IDLE;
      end
      CALC: begin
        fee_d    = grace_hit ? '0 : fee_calc;
        credit_d = '0;
        to_d     = '0;
        state_d  = grace_hit ? PAID : COLLECT;
        pay_d    = grace_hit;
        chg_v_d  = grace_hit;
        chg_d    = grace_hit ? '0 : chg_q;
      end
      COLLECT: begin
        // a coin is accepted before cancel is considered, so a completing coin wins
        if (done) begin
          state_d = PAID;
          pay_d   = 1'b1;
          chg_v_d = 1'b1;
          chg_d   = FEE_W'(sum - {1'b0, fee_q});
        end else if (io.cancel) begin
          state_d = REFUND;
          ref_v_d = 1'b1;
          ref_d   = io.coin_valid ? sum[FEE_W-1:0] : credit_q;
        end else if (io.coin_valid) begin
          credit_d = sum[FEE_W-1:0];
          to_d     = '0;
        end else if (to_q == CW'(TIMEOUT - 1)) begin
          state_d = REFUND;
          ref_v_d = 1'b1;
          ref_d   = credit_q;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      now_q    <= '0;
      tt_q     <= '0;
      credit_q <= '0;
      to_q     <= '0;
      fee_q    <= '0;
      chg_q    <= '0;
      ref_q    <= '0;
      pay_q    <= 1'b0;
      busy_q   <= 1'b0;
      chg_v_q  <= 1'b0;
      ref_v_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      now_q    <= now_d;
      tt_q     <= tt_d;
      credit_q <= credit_d;
      to_q     <= to_d;
      fee_q    <= fee_d;
      chg_q    <= chg_d;
      ref_q    <= ref_d;
      pay_q    <= pay_d;
      busy_q   <= busy_d;
      chg_v_q  <= chg_v_d;
      ref_v_q  <= ref_v_d;
    end
  assign io.pay          = pay_q;
  assign io.busy         = busy_q;
  assign io.fee_due      = fee_q;
  assign io.change_valid = chg_v_q;
  assign io.change       = chg_q;
  assign io.refund_valid = ref_v_q;
  assign io.refund       = ref_q;
endmodule

// File: tb/tb_parking_pay_station.sv
// tb_parking_pay_station: directed and randomized transactions checked against an arithmetic fee/credit model
module tb_parking_pay_station;
  localparam int TO    = 16;
  localparam int RATE  = 2;
  localparam int GRACE = 3;
`ifdef PARKING_GRACE_PERIOD_EN
  localparam bit GR = 1'b1;
`else
  localparam bit GR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int now_m = 0;
  parking_pay_station_if #(.TW(8), .FEE_W(12)) io();
  parking_pay_station #(.TW(8), .RATE(RATE), .FEE_W(12), .TIMEOUT(TO), .GRACE(GRACE)) dut (
    .clk(clk), .rst(rst), .io(io)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    if (io.tick && rst) now_m = (now_m + 1) % 256;
    #1;
  endtask
  task automatic advance(input int n);
    io.tick = 1'b1;
    repeat (n) cyc();
    io.tick = 1'b0;
  endtask
  task automatic set_now(input int t);
    advance((t - now_m + 256) % 256);
  endtask
  task automatic txn(input int tt, input int coins[$], input int cm, input bit rnd);
    int i, c, idle, gap, guard, fee, el, sum, n, v, rv, chg;
    bit done, coin, can, ep, er, free;
    n = coins.size();
    io.tick = 1'b0; io.coin_valid = 1'b0; io.cancel = 1'b0;
    io.ticket_time = 8'(tt); io.ticket_valid = 1'b1;
    cyc();
    io.ticket_valid = 1'b0;
    chk("busy_rise", 32'(io.busy), 1);
    el = (now_m - tt + 256) % 256;
    free = GR && el <= GRACE;
    fee = free ? 0 : ((el == 0 ? 1 : el) * RATE) % 4096;
    cyc();
    chk("fee_due", 32'(io.fee_due), 32'(fee));
    if (free) begin
      chk("grace_pay", 32'(io.pay), 1);
      chk("grace_chg_v", 32'(io.change_valid), 1);
      chk("grace_chg", 32'(io.change), 0);
      cyc();
      chk("grace_busy_end", 32'(io.busy), 0);
      return;
    end
    chk("pay_calc", 32'(io.pay), 0);
    i = 0; c = 0; idle = 0; guard = 0; done = 1'b0;
    gap = rnd ? int'($urandom % 3) : 0;
    while (!done && guard < 400) begin
      guard++;
      io.tick = rnd ? 1'($urandom % 2) : 1'b0;
      io.ticket_valid = rnd ? ($urandom % 4 == 0) : 1'b1;
      io.ticket_time = 8'($urandom);
      coin = (i < n) && gap == 0;
      can = (cm == 1 && coin && i == n - 1) || (cm == 2 && i == n && gap == 0);
      v = coin ? coins[i] : int'($urandom % 16);
      io.coin_valid = coin; io.coin_value = 4'(v); io.cancel = can;
      if (coin) begin
        i++;
        gap = rnd ? int'($urandom % 3) : 0;
      end else if (gap > 0) gap--;
      ep = 1'b0; er = 1'b0; rv = 0; chg = 0;
      if (coin) begin
        sum = c + v; idle = 0;
        if (sum >= fee) begin ep = 1'b1; chg = sum - fee; end
        else if (can) begin er = 1'b1; rv = sum; end
        else c = sum;
      end else if (can) begin er = 1'b1; rv = c; end
      else begin
        idle++;
        if (idle == TO) begin er = 1'b1; rv = c; end
      end
      cyc();
      chk("pay", 32'(io.pay), 32'(ep));
      chk("change_valid", 32'(io.change_valid), 32'(ep));
      chk("refund_valid", 32'(io.refund_valid), 32'(er));
      chk("busy_collect", 32'(io.busy), 1);
      chk("fee_hold", 32'(io.fee_due), 32'(fee));
      if (ep) chk("change", 32'(io.change), 32'(chg));
      if (er) chk("refund", 32'(io.refund), 32'(rv));
      if (ep || er) begin
        done = 1'b1;
        io.tick = 1'b0; io.ticket_valid = 1'b0; io.coin_valid = 1'b0; io.cancel = 1'b0;
        cyc();
        chk("busy_end", 32'(io.busy), 0);
        chk("pay_one_cycle", 32'(io.pay), 0);
        chk("strobes_clear", 32'({io.change_valid, io.refund_valid}), 0);
      end
    end
    io.tick = 1'b0; io.ticket_valid = 1'b0; io.coin_valid = 1'b0; io.cancel = 1'b0;
    chk("txn_done", 32'(done), 1);
  endtask
  initial begin
    int q[$];
    int tt, k, cm;
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int q[$];
    int tt, k, cm, f;
    io.tick = 1'b0; io.ticket_valid = 1'b0; io.ticket_time = '0;
    io.coin_valid = 1'b0; io.coin_value = '0; io.cancel = 1'b0;
    #12;
    chk("rst_pay", 32'(io.pay), 0);
    chk("rst_busy", 32'(io.busy), 0);
    chk("rst_fee", 32'(io.fee_due), 0);
    chk("rst_strobes", 32'({io.change_valid, io.refund_valid}), 0);
    chk("rst_values", 32'({io.change, io.refund}), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc();
    set_now(10);
    q = {5, 5, 5};            txn(4, q, 0, 1'b0);
    set_now(3);
    q = {9, 9};               txn(250, q, 0, 1'b0);
    set_now(7);
    q = {1, 1};               txn(7, q, 0, 1'b0);
    set_now(40);
    q = {5};                  txn(30, q, 2, 1'b0);
    q.delete();               txn(30, q, 2, 1'b0);
    q = {3};                  txn(30, q, 0, 1'b0);
    q = {15, 6};              txn(30, q, 1, 1'b0);
    q = {4, 4};               txn(30, q, 1, 1'b0);
    set_now(42);
    q = {1};                  txn(40, q, 0, 1'b0);
    set_now(100);
    io.ticket_time = 8'(90); io.ticket_valid = 1'b1;
    cyc();
    io.ticket_valid = 1'b0;
    cyc();
    io.coin_valid = 1'b1; io.coin_value = 4'd6;
    cyc();
    io.coin_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_pay", 32'(io.pay), 0);
    chk("arst_busy", 32'(io.busy), 0);
    chk("arst_fee", 32'(io.fee_due), 0);
    chk("arst_strobes", 32'({io.change_valid, io.refund_valid}), 0);
    chk("arst_values", 32'({io.change, io.refund}), 0);
    io.tick = 1'b1;
    @(posedge clk); #1;
    chk("arst_hold_busy", 32'(io.busy), 0);
    io.tick = 1'b0;
    rst = 1'b1;
    now_m = 0;
    q = {1, 1};               txn(0, q, 0, 1'b0);
    for (int t = 0; t < 14; t++) begin
      advance(int'($urandom_range(0, 60)));
      tt = (now_m - int'($urandom_range(0, 40)) + 256) % 256;
      cm = int'($urandom % 3);
      k = int'($urandom_range(0, 12));
      q.delete();
      for (int j = 0; j < k; j++) q.push_back(int'($urandom_range(0, 15)));
      txn(tt, q, cm, 1'b1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
